// File: rtl/minterm_sweeper_pkg.sv
// minterm_sweeper_pkg
// Shared definitions for the minterm sweeper:
//   - state_t      : FSM state encoding (IDLE=0, RUN=1, FIN=2)
//   - DEF_WIDTH_IN / DEF_WIDTH_OUT : default NUM / RES widths
//   - sweep_len()  : number of input codes swept, 2^width_in
package minterm_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH_IN  = 4;
  localparam int DEF_WIDTH_OUT = 3;

  function automatic int sweep_len(input int width_in);
    return 1 << width_in;
  endfunction

endpackage

// File: rtl/minterm_sweeper_if.sv
// minterm_sweeper_if
// Bundles the sweep handshake and capture bus between the sweeper and the
// comparator block under sweep.
//   start : sweep request (sampled by the sweeper only in IDLE)
//   res   : combinational result of the device for the current num
//   num   : registered stimulus code
//   busy  : high while sweeping
//   done  : one-cycle completion pulse
//   mask  : flattened minterm masks, mask[k*2^WIDTH_IN + i] = res[k] at num==i
//   ones  : per-mask population counts (only with MINTERM_SWEEPER_COUNT_EN)
// Modports: master = sweeper side, slave = device/environment side.
interface minterm_sweeper_if
  import minterm_sweeper_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT
);
  localparam int SWEEP_LEN = sweep_len(WIDTH_IN);

  logic                           start;
  logic [WIDTH_OUT-1:0]           res;
  logic [WIDTH_IN-1:0]            num;
  logic                           busy;
  logic                           done;
  logic [WIDTH_OUT*SWEEP_LEN-1:0] mask;
`ifdef MINTERM_SWEEPER_COUNT_EN
  logic [WIDTH_OUT*(WIDTH_IN+1)-1:0] ones;
`endif

  modport master (
    input  start, res,
    output num, busy, done, mask
`ifdef MINTERM_SWEEPER_COUNT_EN
    , output ones
`endif
  );

  modport slave (
    output start, res,
    input  num, busy, done, mask
`ifdef MINTERM_SWEEPER_COUNT_EN
    , input ones
`endif
  );

endinterface

// File: rtl/minterm_sweeper_mask_capture.sv
// mask_capture
// One output bit's truth table: a 2^WIDTH_IN-bit latch register indexed by the
// current stimulus code. When cap_en is high the bit at position idx takes
// bit_in; clr wipes the whole mask (and the ones count).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear mask/count (accepted START)
//   cap_en   : capture enable (RUN state)
//   idx      : current code (NUM)
//   bit_in   : RES[k] for this instance
//   mask     : captured minterm mask
//   ones     : number of 1s captured (only with MINTERM_SWEEPER_COUNT_EN)
module mask_capture
  import minterm_sweeper_pkg::*;
#(
  parameter int WIDTH_IN = DEF_WIDTH_IN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              cap_en,
  input  logic [WIDTH_IN-1:0]               idx,
  input  logic                              bit_in,
  output logic [sweep_len(WIDTH_IN)-1:0]    mask
`ifdef MINTERM_SWEEPER_COUNT_EN
  , output logic [WIDTH_IN:0]               ones
`endif
);
  localparam int SWEEP_LEN = sweep_len(WIDTH_IN);

  logic [SWEEP_LEN-1:0] mask_q;
  logic [SWEEP_LEN-1:0] mask_d;

  // Per-bit decode: only the bit addressed by idx can change during capture.
  genvar gi;
  generate
    for (gi = 0; gi < SWEEP_LEN; gi++) begin : g_bit
      assign mask_d[gi] = clr ? 1'b0 :
                          (cap_en && (idx == WIDTH_IN'(gi))) ? bit_in :
                          mask_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign mask = mask_q;

`ifdef MINTERM_SWEEPER_COUNT_EN
  logic [WIDTH_IN:0] ones_q;
  logic [WIDTH_IN:0] ones_d;

  // One extra bit so a mask of all ones (2^WIDTH_IN) is representable.
  always_comb begin
    ones_d = ones_q;
    if (clr)                  ones_d = '0;
    else if (cap_en && bit_in) ones_d = ones_q + (WIDTH_IN+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ones_q <= '0;
    else     ones_q <= ones_d;
  end

  assign ones = ones_q;
`endif

endmodule

// File: rtl/minterm_sweeper.sv
// minterm_sweeper
// Drives NUM through every code 0..2^WIDTH_IN-1 (one per clock) after START,
// latching each RES bit into a per-bit minterm mask, then pulses DONE.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (abandons any sweep in progress)
//   bus : minterm_sweeper_if.master (start/res in; num/busy/done/mask[/ones] out)
// Optional feature: define MINTERM_SWEEPER_COUNT_EN to add per-mask ones counts
// on bus.ones.
module minterm_sweeper
  import minterm_sweeper_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT
) (
  input  logic               clk,
  input  logic               rst,
  minterm_sweeper_if.master  bus
);
  localparam int SWEEP_LEN = sweep_len(WIDTH_IN);
  localparam logic [WIDTH_IN-1:0] LAST_CODE = WIDTH_IN'(SWEEP_LEN - 1);

  state_t              state_q, state_d;
  logic [WIDTH_IN-1:0] num_q, num_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                clr;
  logic                cap_en;

  // START is only honoured in IDLE, so a request during RUN/FIN is dropped.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          num_d   = '0;
        end
      end
      ST_RUN: begin
        // Return to 0 is explicit; NUM never counts past the last code.
        if (num_q == LAST_CODE) begin
          state_d = ST_FIN;
          num_d   = '0;
        end else begin
          num_d = num_q + WIDTH_IN'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        num_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr    = (state_q == ST_IDLE) && bus.start;
  assign cap_en = (state_q == ST_RUN);

  logic [WIDTH_OUT*SWEEP_LEN-1:0] mask_w;
`ifdef MINTERM_SWEEPER_COUNT_EN
  logic [WIDTH_OUT*(WIDTH_IN+1)-1:0] ones_w;
`endif

  // Mask k occupies bits [k*2^WIDTH_IN +: 2^WIDTH_IN], so bit index inside the
  // slice is NUM and the flattened index is k*2^WIDTH_IN + NUM.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_OUT; gi++) begin : g_cap
      mask_capture #(
        .WIDTH_IN (WIDTH_IN)
      ) u_cap (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .cap_en (cap_en),
        .idx    (num_q),
        .bit_in (bus.res[gi]),
        .mask   (mask_w[gi*SWEEP_LEN +: SWEEP_LEN])
`ifdef MINTERM_SWEEPER_COUNT_EN
        , .ones (ones_w[gi*(WIDTH_IN+1) +: (WIDTH_IN+1)])
`endif
      );
    end
  endgenerate

  assign bus.num  = num_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mask = mask_w;
`ifdef MINTERM_SWEEPER_COUNT_EN
  assign bus.ones = ones_w;
`endif

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper
// Self-checking bench: table of truth tables (fixed + random) swept end to end,
// plus hand-written sequences for mid-sweep capture, ignored START, async reset
// and back-to-back sweeps with START held high.
module tb_minterm_sweeper;

  localparam int WI = 4;
  localparam int WO = 3;
  localparam int SL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  minterm_sweeper_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) sw_if ();

  minterm_sweeper #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if.master)
  );

  // Device under sweep: a truth table looked up by the current NUM.
  logic [2:0] cur_lut [SL];
  assign sw_if.res = cur_lut[sw_if.num];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  lut [SL];
    logic [47:0] exp_mask;
    logic [14:0] exp_ones;
  } vec_t;

  // Reference model: mask k, minterm i = bit k of the truth table at code i.
  function automatic logic [47:0] ref_mask(input logic [2:0] l [SL]);
    logic [47:0] m = '0;
    for (int k = 0; k < WO; k++)
      for (int i = 0; i < SL; i++)
        m[k*SL + i] = l[i][k];
    return m;
  endfunction

  function automatic logic [14:0] ref_ones(input logic [2:0] l [SL]);
    logic [14:0] o = '0;
    for (int k = 0; k < WO; k++) begin
      int c = 0;
      for (int i = 0; i < SL; i++) c += int'(l[i][k]);
      o[k*5 +: 5] = 5'(c);
    end
    return o;
  endfunction

  vec_t vecs [7];
  logic [2:0] model_lut [SL];

  // Full sweep from an IDLE negedge; ends on the negedge after DONE falls.
  task automatic run_sweep(input string nm, input logic [47:0] em, input logic [14:0] eo);
    int cyc;
    int busy_cnt;
    sw_if.start = 1'b1;
    @(negedge clk);
    sw_if.start = 1'b0;
    chk({nm, "_busy_start"}, sw_if.busy, 1);
    chk({nm, "_mask_cleared"}, sw_if.mask, 0);
    cyc = 0;
    busy_cnt = 0;
    while (!sw_if.done && cyc < 40) begin
      if (sw_if.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_latency"}, cyc, 16);
    chk({nm, "_busy_cycles"}, busy_cnt, 16);
    chk({nm, "_mask"}, sw_if.mask, em);
`ifdef MINTERM_SWEEPER_COUNT_EN
    chk({nm, "_ones"}, sw_if.ones, eo);
`else
    if (eo === 15'bx) $display("note: no ones port");
`endif
    @(negedge clk);
    chk({nm, "_done_pulse_width"}, sw_if.done, 0);
  endtask

  initial begin
    int cyc;
    int rises;
    int last_rise;
    logic prev_busy;
    logic saw_activity;

    // Fill vector table.
    for (int i = 0; i < SL; i++) model_lut[i] = {i < 3, i > 7, i != 5};
    vecs[0].name = "spec_model";
    vecs[0].lut = model_lut;
    vecs[0].exp_mask = 48'h0007_FF00_FFDF;
    vecs[0].exp_ones = {5'd3, 5'd8, 5'd15};
    vecs[1].name = "all_ones";
    for (int i = 0; i < SL; i++) vecs[1].lut[i] = 3'b111;
    vecs[1].exp_mask = {48{1'b1}};
    vecs[1].exp_ones = {5'd16, 5'd16, 5'd16};
    vecs[2].name = "all_zero";
    for (int i = 0; i < SL; i++) vecs[2].lut[i] = 3'b000;
    vecs[2].exp_mask = '0;
    vecs[2].exp_ones = '0;
    for (int r = 3; r < 7; r++) begin
      vecs[r].name = $sformatf("random%0d", r - 3);
      for (int i = 0; i < SL; i++) vecs[r].lut[i] = 3'($urandom_range(0, 7));
      vecs[r].exp_mask = ref_mask(vecs[r].lut);
      vecs[r].exp_ones = ref_ones(vecs[r].lut);
    end

    cur_lut = model_lut;
    sw_if.start = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_num", sw_if.num, 0);
    chk("reset_busy", sw_if.busy, 0);
    chk("reset_done", sw_if.done, 0);
    chk("reset_mask", sw_if.mask, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps.
    for (int r = 0; r < 7; r++) begin
      cur_lut = vecs[r].lut;
      run_sweep(vecs[r].name, vecs[r].exp_mask, vecs[r].exp_ones);
    end

    // Capture of code 10 visible once NUM has moved on to 11.
    cur_lut = model_lut;
    sw_if.start = 1'b1;
    @(negedge clk);
    sw_if.start = 1'b0;
    cyc = 0;
    while (sw_if.num != 4'd11 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("num10_reached", sw_if.num, 11);
    chk("num10_capture", {sw_if.mask[42], sw_if.mask[26], sw_if.mask[10]}, 3'b011);
    cyc = 0;
    while (!sw_if.done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("num10_done", sw_if.done, 1);
    @(negedge clk);

    // START pulsed again mid-sweep is ignored.
    sw_if.start = 1'b1;
    @(negedge clk);
    sw_if.start = 1'b0;
    cyc = 0;
    while (sw_if.num != 4'd6 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("restart_at_num6", cyc, 6);
    sw_if.start = 1'b1;
    @(negedge clk);
    cyc++;
    sw_if.start = 1'b0;
    while (!sw_if.done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("restart_done_time", cyc, 16);
    chk("restart_mask", sw_if.mask, 48'h0007_FF00_FFDF);
    @(negedge clk);
    chk("restart_idle_after", sw_if.busy, 0);

    // Asynchronous reset mid-sweep.
    sw_if.start = 1'b1;
    @(negedge clk);
    sw_if.start = 1'b0;
    cyc = 0;
    while (sw_if.num != 4'd9 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("areset_at_num9", sw_if.num, 9);
    #2 rst = 1'b1;
    #1;
    chk("areset_num", sw_if.num, 0);
    chk("areset_busy", sw_if.busy, 0);
    chk("areset_done", sw_if.done, 0);
    chk("areset_mask", sw_if.mask, 0);
    rst = 1'b0;
    saw_activity = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (sw_if.done || sw_if.busy) saw_activity = 1'b1;
    end
    chk("areset_no_resume", saw_activity, 0);
    cur_lut = model_lut;
    run_sweep("after_reset", 48'h0007_FF00_FFDF, {5'd3, 5'd8, 5'd15});

    // START held high: back-to-back sweeps every 18 cycles, mask cleared at each restart.
    sw_if.start = 1'b1;
    rises = 0;
    last_rise = 0;
    prev_busy = sw_if.busy;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sw_if.busy && !prev_busy) begin
        if (rises > 0) chk($sformatf("held_period%0d", rises), n - last_rise, 18);
        chk($sformatf("held_mask_clear%0d", rises), sw_if.mask, 0);
        rises++;
        last_rise = n;
      end
      if (sw_if.done)
        chk($sformatf("held_mask_at_done%0d", rises), sw_if.mask, 48'h0007_FF00_FFDF);
      prev_busy = sw_if.busy;
    end
    chk("held_sweep_count", rises, 4);
    sw_if.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("held_final_idle", sw_if.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
